// File: rtl/life_col4.sv
// life_col4: four-cell vertical Conway Game-of-Life column (bit 0 = north), tileable into a board.
// Optional build macro LIFE_COL_HIGHLIFE_EN selects the HighLife rule B36/S23 instead of B3/S23.
module life_col4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] w_col,
  input  logic [3:0] e_col,
  input  logic       n,
  input  logic       s,
  input  logic       nw,
  input  logic       ne,
  input  logic       sw,
  input  logic       se,
  input  logic       write_enb,
  input  logic [3:0] val,
  input  logic       enable,
  output logic [3:0] alive_col,
  output logic [3:0] alive_prev_col
);

  logic [3:0] alive_r;
  logic [3:0] alive_prev_r;
  logic [3:0] next_s;
  logic [5:0] mid_ext_s;
  logic [5:0] west_ext_s;
  logic [5:0] east_ext_s;

  // Population count of the eight neighbour bits, 0..8.
  function automatic logic [3:0] count8(input logic [7:0] nb);
    logic [3:0] sum;
    sum = 4'd0;
    for (int k = 0; k < 8; k++) begin
      sum = sum + {3'b000, nb[k]};
    end
    return sum;
  endfunction

  // Birth/survival rule for one cell.
  function automatic logic rule_next(input logic cur, input logic [3:0] cnt);
    logic res;
    if (cur) begin
      case (cnt)
        4'd2, 4'd3: res = 1'b1;
        default:    res = 1'b0;
      endcase
    end else begin
      case (cnt)
`ifdef LIFE_COL_HIGHLIFE_EN
        4'd3, 4'd6: res = 1'b1;
`else
        4'd3:       res = 1'b1;
`endif
        default:    res = 1'b0;
      endcase
    end
    return res;
  endfunction

  // Column edges padded with the boundary inputs so every cell sees rows i..i+2 of each strip.
  assign mid_ext_s  = {s,  alive_r, n};
  assign west_ext_s = {sw, w_col,   nw};
  assign east_ext_s = {se, e_col,   ne};

  // Next generation for all four cells from the current registered state.
  always_comb begin
    next_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      next_s[i] = rule_next(alive_r[i],
                            count8({mid_ext_s[i], mid_ext_s[i+2],
                                    west_ext_s[i], west_ext_s[i+1], west_ext_s[i+2],
                                    east_ext_s[i], east_ext_s[i+1], east_ext_s[i+2]}));
    end
  end

  // State and previous-state registers: reset > write > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive_r      <= 4'b0000;
      alive_prev_r <= 4'b0000;
    end else if (write_enb) begin
      alive_r      <= val;
      alive_prev_r <= alive_r;
    end else if (enable) begin
      alive_r      <= next_s;
      alive_prev_r <= alive_r;
    end else begin
      alive_r      <= alive_r;
      alive_prev_r <= alive_prev_r;
    end
  end

  assign alive_col      = alive_r;
  assign alive_prev_col = alive_prev_r;

endmodule

// File: tb/tb_life_col4.sv
// Directed self-checking bench for life_col4; expected values are hand-computed generations.
// Honors LIFE_COL_HIGHLIFE_EN for the count-6 birth check.
module tb_life_col4;

  logic       clk;
  logic       reset;
  logic [3:0] w_col;
  logic [3:0] e_col;
  logic       n;
  logic       s;
  logic       nw;
  logic       ne;
  logic       sw;
  logic       se;
  logic       write_enb;
  logic [3:0] val;
  logic       enable;
  logic [3:0] alive_col;
  logic [3:0] alive_prev_col;

  int compared;
  int mismatched;

  life_col4 dut (
    .clk(clk), .reset(reset), .w_col(w_col), .e_col(e_col),
    .n(n), .s(s), .nw(nw), .ne(ne), .sw(sw), .se(se),
    .write_enb(write_enb), .val(val), .enable(enable),
    .alive_col(alive_col), .alive_prev_col(alive_prev_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; w_col = 4'b0000; e_col = 4'b0000;
    n = 1'b0; s = 1'b0; nw = 1'b0; ne = 1'b0; sw = 1'b0; se = 1'b0;
    write_enb = 1'b0; val = 4'b0000; enable = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (alive_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_alive: got %b expected 0000", alive_col);
    end
    compared++;
    if (alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_prev: got %b expected 0000", alive_prev_col);
    end
  endtask

  task automatic test_birth_stabilise();
    logic [3:0] exp_a [0:7];
    exp_a = '{4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    clear_inputs();
    enable = 1'b1; n = 1'b1; w_col = 4'b0001; e_col = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      compared++;
      if (alive_col !== exp_a[k]) begin
        mismatched++;
        $display("FAIL birth_gen%0d: got %b expected %b", k + 1, alive_col, exp_a[k]);
      end
    end
    compared++;
    if (alive_prev_col !== 4'b0010) begin
      mismatched++;
      $display("FAIL birth_prev: got %b expected 0010", alive_prev_col);
    end
  endtask

  task automatic test_write_hold();
    clear_inputs();
    write_enb = 1'b1; val = 4'b1111;
    tick();
    compared++;
    if (alive_col !== 4'b1111 || alive_prev_col !== 4'b0010) begin
      mismatched++;
      $display("FAIL write_load: got %b/%b expected 1111/0010", alive_col, alive_prev_col);
    end
    write_enb = 1'b0; val = 4'b0000;
    // Neighbours that would kill/birth cells must not matter while held.
    w_col = 4'b1111; e_col = 4'b1111; n = 1'b1; s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if (alive_col !== 4'b1111 || alive_prev_col !== 4'b0010) begin
        mismatched++;
        $display("FAIL hold_%0d: got %b/%b expected 1111/0010", k, alive_col, alive_prev_col);
      end
    end
  endtask

  task automatic test_death();
    clear_inputs();
    enable = 1'b1;
    tick();
    compared++;
    if (alive_col !== 4'b0110 || alive_prev_col !== 4'b1111) begin
      mismatched++;
      $display("FAIL death_1: got %b/%b expected 0110/1111", alive_col, alive_prev_col);
    end
    tick();
    compared++;
    if (alive_col !== 4'b0000 || alive_prev_col !== 4'b0110) begin
      mismatched++;
      $display("FAIL death_2: got %b/%b expected 0000/0110", alive_col, alive_prev_col);
    end
    tick();
    compared++;
    if (alive_col !== 4'b0000 || alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL death_3: got %b/%b expected 0000/0000", alive_col, alive_prev_col);
    end
  endtask

  task automatic test_prev();
    do_reset();
    e_col = 4'b0111; enable = 1'b1;
    tick();
    compared++;
    if (alive_col !== 4'b0010 || alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL prev_1: got %b/%b expected 0010/0000", alive_col, alive_prev_col);
    end
    e_col = 4'b0000;
    tick();
    compared++;
    if (alive_col !== 4'b0000 || alive_prev_col !== 4'b0010) begin
      mismatched++;
      $display("FAIL prev_2: got %b/%b expected 0000/0010", alive_col, alive_prev_col);
    end
    tick();
    compared++;
    if (alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL prev_3: got %b expected 0000", alive_prev_col);
    end
  endtask

  task automatic test_count6();
    logic [3:0] exp_a;
`ifdef LIFE_COL_HIGHLIFE_EN
    exp_a = 4'b0010;
`else
    exp_a = 4'b0000;
`endif
    // Dead cell 1 sees six side neighbours; cells 0 and 2 see four, cell 3 two.
    do_reset();
    w_col = 4'b0111; e_col = 4'b0111; enable = 1'b1;
    tick();
    compared++;
    if (alive_col !== exp_a) begin
      mismatched++;
      $display("FAIL count6: got %b expected %b", alive_col, exp_a);
    end
  endtask

  task automatic test_priority();
    do_reset();
    n = 1'b1; w_col = 4'b0001; e_col = 4'b0001;
    enable = 1'b1; write_enb = 1'b1; val = 4'b1010;
    tick();
    compared++;
    if (alive_col !== 4'b1010 || alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL prio_write: got %b/%b expected 1010/0000", alive_col, alive_prev_col);
    end
    reset = 1'b1; val = 4'b0101;
    tick();
    compared++;
    if (alive_col !== 4'b0000 || alive_prev_col !== 4'b0000) begin
      mismatched++;
      $display("FAIL prio_reset: got %b/%b expected 0000/0000", alive_col, alive_prev_col);
    end
    clear_inputs();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_birth_stabilise();
    test_write_hold();
    test_death();
    test_prev();
    test_count6();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/life_col4.md
Name: life_col4

Overview:
- Vertical column of 4 Conway Game-of-Life cells. Each cell is one state flop plus neighbour-count and rule logic.
- Bit 0 is the top (north) cell and bit 3 the bottom (south) cell.
- Tiles horizontally and vertically into the board array. Neighbouring columns drive w_col/e_col, neighbouring column ends drive n/s and the corner inputs.
- Each cycle the block either advances one generation, loads a written pattern, or holds.

Parameters:
- None. Column height is fixed at 4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears all state
- w_col  input  4  alive states of the west column, same bit order as alive_col
- e_col  input  4  alive states of the east column, same bit order as alive_col
- n  input  1  cell directly above bit 0
- s  input  1  cell directly below bit 3
- nw  input  1  cell above-west of bit 0
- ne  input  1  cell above-east of bit 0
- sw  input  1  cell below-west of bit 3
- se  input  1  cell below-east of bit 3
- write_enb  input  1  load val into the column
- val  input  4  pattern to load
- enable  input  1  advance one generation this cycle
- alive_col  output  4  current cell states (registered)
- alive_prev_col  output  4  cell states before the most recent load/step (registered)

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Neighbours of cell i (i = 0..3), 8 total:
  - Same-row side cells: w_col[i], e_col[i].
  - Above (i-1): cell i-1, w_col[i-1], e_col[i-1]. For i=0 use n, nw, ne.
  - Below (i+1): cell i+1, w_col[i+1], e_col[i+1]. For i=3 use s, sw, se.
- Count is 0..8 and needs a 4-bit unsigned sum.
- Conway rule:
  - Dead cell becomes alive iff count == 3.
  - Alive cell stays alive iff count == 2 or 3; otherwise it dies.
- All next-state values are computed from the current registered states, so all four cells update simultaneously.
- Per rising edge, priority order:
  1. reset=1: alive_col <= 0, alive_prev_col <= 0. Ignores write_enb and enable.
  2. else write_enb=1: alive_col <= val, alive_prev_col <= old alive_col. enable is ignored; write takes priority over a step in the same cycle.
  3. else enable=1: alive_col <= rule result, alive_prev_col <= old alive_col.
  4. else: both registers hold.
- Latency: one cycle from input change to updated alive_col. Outputs come straight from flops, with no combinational path from inputs to outputs.
- Outputs are 0 after reset. Before the first reset, state is undefined.
- Neighbour inputs are sampled only on a step edge. Changes between edges have no effect.

Optional Feature:
- Macro LIFE_COL_HIGHLIFE_EN.
- Defined: HighLife rule B36/S23. A dead cell is born on count == 3 or count == 6; survival is unchanged (2 or 3).
- Undefined: standard B3/S23 as above.
- Write, reset and hold paths are identical in both builds.

Test Plan:
- Reset: assert reset one edge, all inputs 0 -> alive_col=0000, alive_prev_col=0000.
- Birth and stabilise: enable=1, n=1, w_col=e_col=0001, other inputs 0.
  - After 1 edge alive_col=0001; after 2 edges 0011; after 3 edges 0010.
  - Stays 0010 for 5 further edges.
- Write while disabled: enable=0, all neighbours 0, write_enb=1 with val=1111 for one edge -> alive_col=1111. Then hold with write_enb=0 -> stays 1111.
- Death: from 1111 with neighbours 0, enable=1 -> 0110 after 1 edge, 0000 after 2 edges, then stays 0000.
- Previous state: reset, then e_col=0111, enable=1.
  - After 1 edge: alive_col=0010, alive_prev_col=0000.
  - Then e_col=0, next edge: alive_col=0000, alive_prev_col=0010.
  - Next edge: alive_prev_col=0000.
- Priority: write_enb=1, enable=1, val=1010 with neighbours that would cause births -> alive_col=1010. Asserting reset together with write_enb -> alive_col=0000.
